// File: rtl/fp_packer.sv
// Two-stage packer: turns an unpacked FP result (sign, exponent, significand, flags)
// into an IEEE-754 single or double word with full valid/ready backpressure.
module fp_packer #(
  parameter int EW = 11,
  parameter int FW = 53
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          db,
  input  logic          s,
  input  logic [EW-1:0] e,
  input  logic [FW-1:0] f,
  input  logic          is_nan,
  input  logic          is_inf,
  input  logic          is_zero,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   fp,
  output logic          ovf
);

  typedef enum logic [2:0] {
    SEL_NORM,
    SEL_DEN,
    SEL_ZERO,
    SEL_INF,
    SEL_NAN
  } sel_t;

  logic        s1_valid;
  logic        s1_db;
  logic        s1_s;
  sel_t        s1_sel;
  logic        s1_ovf;
  logic [10:0] s1_exp;
  logic [51:0] s1_frac;

  logic        s2_adv;
  logic        s1_adv;

  sel_t        in_sel;
  logic        in_sat;
  logic        exp_max;

  logic [63:0] asm_word;

  // A full pipeline still accepts when the consumer drains this cycle (no bubble).
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s2_adv || !s1_valid;
  assign in_ready = s1_adv;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    in_sel  = SEL_NORM;
    in_sat  = 1'b0;
    exp_max = db ? (e[10:0] == 11'h7FF) : (e[7:0] == 8'hFF);
    if (is_nan) begin
      in_sel = SEL_NAN;
    end else if (is_inf) begin
      in_sel = SEL_INF;
    end else if (is_zero) begin
      in_sel = SEL_ZERO;
    end else if (!f[52]) begin
      in_sel = SEL_DEN;
    end else if (exp_max) begin
      // A normal value with an all-ones exponent has overflowed the format.
      in_sel = SEL_INF;
      in_sat = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: payload flops carry no reset; s1_valid qualifies them, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_db   <= db;
      s1_s    <= s;
      s1_sel  <= in_sel;
      s1_ovf  <= in_sat;
      s1_exp  <= e[10:0];
      s1_frac <= f[51:0];
    end
  end

  always_comb begin
    asm_word = 64'h0;
    if (s1_db) begin
      case (s1_sel)
        SEL_NAN:  asm_word = 64'h7FF8_0000_0000_0000;
        SEL_INF:  asm_word = {s1_s, 11'h7FF, 52'h0};
        SEL_ZERO: asm_word = {s1_s, 63'h0};
        SEL_DEN:  asm_word = {s1_s, 11'h000, s1_frac};
        default:  asm_word = {s1_s, s1_exp, s1_frac};
      endcase
    end else begin
      // Single keeps the top 23 fraction bits; the rounder has already cleared the rest.
      case (s1_sel)
        SEL_NAN:  asm_word = {32'h0, 32'h7FC0_0000};
        SEL_INF:  asm_word = {32'h0, s1_s, 8'hFF, 23'h0};
        SEL_ZERO: asm_word = {32'h0, s1_s, 31'h0};
        SEL_DEN:  asm_word = {32'h0, s1_s, 8'h00, s1_frac[51:29]};
        default:  asm_word = {32'h0, s1_s, s1_exp[7:0], s1_frac[51:29]};
      endcase
    end
  end

  // Output register holds fp/ovf while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      fp        <= 64'h0;
      ovf       <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        fp  <= asm_word;
        ovf <= s1_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fp_packer.sv
// Scoreboard bench for fp_packer: a stimulus side queues expected words, a monitor
// compares every presented output against the queue head.
module tb_fp_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        db;
  logic        s;
  logic [10:0] e;
  logic [52:0] f;
  logic        is_nan;
  logic        is_inf;
  logic        is_zero;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] fp;
  logic        ovf;

  typedef struct packed {
    logic        db;
    logic        s;
    logic [10:0] e;
    logic [52:0] f;
    logic        nan;
    logic        inf;
    logic        zero;
  } stim_t;

  typedef struct packed {
    logic [63:0] fp;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  fp_packer #(.EW(11), .FW(53)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .db        (db),
    .s         (s),
    .e         (e),
    .f         (f),
    .is_nan    (is_nan),
    .is_inf    (is_inf),
    .is_zero   (is_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fp        (fp),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Reference: IEEE field assembly written straight from the format rules.
  function automatic exp_t ref_pack(input stim_t t);
    exp_t        r;
    logic        sat;
    logic [7:0]  e8;
    logic [22:0] m23;
    e8  = t.e[7:0];
    m23 = t.f[51:29];
    sat = !t.nan && !t.inf && !t.zero && t.f[52] &&
          (t.db ? (t.e == 11'd2047) : (e8 == 8'd255));
    r.ovf = sat;
    if (t.db) begin
      if (t.nan)              r.fp = 64'h7FF8_0000_0000_0000;
      else if (t.inf || sat)  r.fp = {t.s, 11'h7FF, 52'h0};
      else if (t.zero)        r.fp = {t.s, 63'h0};
      else if (!t.f[52])      r.fp = {t.s, 11'h0, t.f[51:0]};
      else                    r.fp = {t.s, t.e, t.f[51:0]};
    end else begin
      if (t.nan)              r.fp = 64'h0000_0000_7FC0_0000;
      else if (t.inf || sat)  r.fp = {32'h0, t.s, 8'hFF, 23'h0};
      else if (t.zero)        r.fp = {32'h0, t.s, 31'h0};
      else if (!t.f[52])      r.fp = {32'h0, t.s, 8'h0, m23};
      else                    r.fp = {32'h0, t.s, e8, m23};
    end
    return r;
  endfunction

  function automatic stim_t mk(input logic d, input logic sg, input logic [10:0] ex,
                               input logic [52:0] fr, input logic n, input logic i, input logic z);
    stim_t t;
    t.db = d; t.s = sg; t.e = ex; t.f = fr; t.nan = n; t.inf = i; t.zero = z;
    return t;
  endfunction

  function automatic stim_t rnd_stim();
    stim_t t;
    t.db   = 1'($urandom_range(0, 1));
    t.s    = 1'($urandom_range(0, 1));
    t.e    = 11'($urandom);
    if ($urandom_range(0, 7) == 0) t.e = t.db ? 11'h7FF : {3'($urandom), 8'hFF};
    t.f    = {1'b0, 20'($urandom), 32'($urandom)};
    t.f[52] = ($urandom_range(0, 7) != 0);
    if (!t.db) t.f[28:0] = 29'h0;
    t.nan  = ($urandom_range(0, 15) == 0);
    t.inf  = ($urandom_range(0, 15) == 0);
    t.zero = ($urandom_range(0, 15) == 0);
    return t;
  endfunction

  // Presents one word and holds it until accepted; leaves in_valid high for back-to-back use.
  task automatic send(input stim_t t, input exp_t x, output bit ok);
    db = t.db; s = t.s; e = t.e; f = t.f;
    is_nan = t.nan; is_inf = t.inf; is_zero = t.zero;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(x);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 64 cycles expected acceptance");
      in_valid = 1'b0;
    end
  endtask

  // Single word into an empty pipeline with explicit latency checks.
  task automatic directed(input string name, input stim_t t, input exp_t x);
    bit ok;
    send(t, x, ok);
    in_valid = 1'b0;
    if (ok) begin
      check({name, "_lat1"}, 64'(out_valid), 64'h0);
      @(posedge clk);
      #1;
      check({name, "_lat2"}, 64'(out_valid), 64'h1);
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL spurious_out: got fp=%h expected no word", fp);
      end else begin
        check("mon_fp", fp, sb[0].fp);
        check("mon_ovf", 64'(ovf), 64'(sb[0].ovf));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit    ok;
    bit    saw_drop;
    bit    ready_drop;
    bit    done;
    int    cnt;
    int    first;
    int    last;
    stim_t t;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    db = 1'b0; s = 1'b0; e = '0; f = '0; is_nan = 1'b0; is_inf = 1'b0; is_zero = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_fp", fp, 64'h0);
    check("rst_ovf", 64'(ovf), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'h1);

    directed("dbl_one", mk(1, 0, 11'd1023, 53'h10_0000_0000_0000, 0, 0, 0),
             exp_t'({64'h3FF0_0000_0000_0000, 1'b0}));
    directed("sgl_norm", mk(0, 1, 11'd127, 53'h18_0000_0000_0000, 0, 0, 0),
             exp_t'({64'h0000_0000_BFC0_0000, 1'b0}));
    directed("sgl_den", mk(0, 0, 11'd0, 53'h00_0800_0000_0000, 0, 0, 0),
             exp_t'({64'h0000_0000_0000_4000, 1'b0}));
    directed("nan_prio", mk(1, 1, 11'd5, 53'h10_0000_0000_0000, 1, 1, 0),
             exp_t'({64'h7FF8_0000_0000_0000, 1'b0}));
    directed("dbl_sat", mk(1, 1, 11'd2047, 53'h10_0000_0000_0000, 0, 0, 0),
             exp_t'({64'hFFF0_0000_0000_0000, 1'b1}));
    directed("sgl_sat", mk(0, 0, 11'h0FF, 53'h1F_FFFF_E000_0000, 0, 0, 0),
             exp_t'({64'h0000_0000_7F80_0000, 1'b1}));
    directed("zero_prio", mk(1, 1, 11'd2047, 53'h10_0000_0000_0000, 0, 0, 1),
             exp_t'({64'h8000_0000_0000_0000, 1'b0}));

    // Backpressure: four words, consumer stalls three cycles after first out_valid.
    saw_drop = 1'b0;
    cnt      = 0;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          t = mk(1, 0, 11'(100 + k), {1'b1, 52'(k + 1)}, 0, 0, 0);
          send(t, ref_pack(t), ok);
        end
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 50 && !out_valid; i++) begin
          @(posedge clk);
          #1;
        end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (!in_ready) saw_drop = 1'b1;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
        repeat (4) begin
          @(negedge clk);
          if (out_valid && out_ready) cnt++;
          @(posedge clk);
          #1;
        end
      end
    join
    check("bp_in_ready_drop", 64'(saw_drop), 64'h1);
    check("bp_no_gaps", 64'(cnt), 64'd4);
    repeat (3) @(posedge clk);
    #1;

    // Continuous throughput: eight back-to-back words.
    ready_drop = 1'b0;
    cnt = 0; first = -1; last = -1;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          t = rnd_stim();
          send(t, ref_pack(t), ok);
        end
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 14; i++) begin
          @(negedge clk);
          if (i < 8 && !in_ready) ready_drop = 1'b1;
          if (out_valid) begin
            cnt++;
            if (first < 0) first = i;
            last = i;
          end
          @(posedge clk);
          #1;
        end
      end
    join
    check("tp_in_ready", 64'(ready_drop), 64'h0);
    check("tp_count", 64'(cnt), 64'd8);
    check("tp_first", 64'(first), 64'd2);
    check("tp_span", 64'(last - first), 64'd7);

    // Reset with two words in flight.
    t = rnd_stim();
    send(t, ref_pack(t), ok);
    t = rnd_stim();
    send(t, ref_pack(t), ok);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'h0);
    check("mid_rst_fp", fp, 64'h0);
    check("mid_rst_ovf", 64'(ovf), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'h1);
    directed("post_rst", mk(1, 0, 11'd1024, 53'h18_0000_0000_0000, 0, 0, 0),
             exp_t'({64'h4008_0000_0000_0000, 1'b0}));
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_no_stale", 64'(sb.size()), 64'h0);

    // Randomized traffic with random consumer stalls.
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          t = rnd_stim();
          send(t, ref_pack(t), ok);
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join

    for (int i = 0; i < 50 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 64'(sb.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
